// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C configuration request arbiter: FSM encoding,
// transfer-word width and the audio codec slave address.
package i2c_cfg_pkg;

  localparam int unsigned XFER_W  = 24;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT    = 3'd2;
  localparam logic [STATE_W-1:0] ST_REISSUE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

  localparam logic [7:0] CODEC_ADDR = 8'h34;

  typedef logic [XFER_W-1:0] xferWord_t;

endpackage

// File: rtl/i2c_clk_tick.sv
// Work-clock divider: toggles oCTRL_CLK every DIV+1 iCLK cycles and flags the
// iCLK cycle just before each work-clock rising edge.
module i2c_clk_tick #(
  parameter int unsigned DIV = 1200
) (
  input  logic iCLK,
  input  logic iRST_N,
  output logic oCTRL_CLK,
  output logic oTick_c
);

  localparam int unsigned CNT_W = (DIV < 1) ? 1 : $clog2(DIV + 1);

  logic [CNT_W-1:0] divCnt;
  logic             atTop_c;

  assign atTop_c = (divCnt == CNT_W'(DIV));
  assign oTick_c = atTop_c && !oCTRL_CLK;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      divCnt    <= '0;
      oCTRL_CLK <= 1'b0;
    end else if (atTop_c) begin
      divCnt    <= '0;
      oCTRL_CLK <= ~oCTRL_CLK;
    end else begin
      divCnt <= divCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin owner of one I2C byte-triple controller shared by the codec boot
// sequencer (req0) and runtime control (req1), with NACK retry and watchdog.
module i2c_req_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 24000000,
  parameter int unsigned I2C_FREQ  = 20000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iREQ0,
  input  logic [XFER_W-1:0] iDATA0,
  output logic              oDONE0,
  output logic              oERR0,
  input  logic              iREQ1,
  input  logic [XFER_W-1:0] iDATA1,
  output logic              oDONE1,
  output logic              oERR1,
  output logic              oCTRL_CLK,
  output logic [XFER_W-1:0] oI2C_DATA,
  output logic              oI2C_GO,
  input  logic              iI2C_END,
  input  logic              iI2C_ACK,
  output logic              oBUSY
);

  localparam int unsigned DIV = CLK_FREQ / I2C_FREQ;

  logic tick_c;

  i2c_clk_tick #(.DIV(DIV)) uClkTick (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .oCTRL_CLK (oCTRL_CLK),
    .oTick_c   (tick_c)
  );

  logic [STATE_W-1:0] state, stateNext;
  logic               owner, ownerNext;
  logic               prefer, preferNext;
  logic               errFlag, errNext;
  logic [1:0]         retryCnt, retryNext;
  logic [7:0]         tmoCnt, tmoNext;
  logic               goNext, busyNext;
  xferWord_t          dataNext;
  logic               done0Next, done1Next, err0Next, err1Next;
  logic               grant1;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      prefer    <= 1'b0;
      errFlag   <= 1'b0;
      retryCnt  <= '0;
      tmoCnt    <= '0;
      oI2C_GO   <= 1'b0;
      oI2C_DATA <= '0;
      oBUSY     <= 1'b0;
      oDONE0    <= 1'b0;
      oDONE1    <= 1'b0;
      oERR0     <= 1'b0;
      oERR1     <= 1'b0;
    end else begin
      state     <= stateNext;
      owner     <= ownerNext;
      prefer    <= preferNext;
      errFlag   <= errNext;
      retryCnt  <= retryNext;
      tmoCnt    <= tmoNext;
      oI2C_GO   <= goNext;
      oI2C_DATA <= dataNext;
      oBUSY     <= busyNext;
      oDONE0    <= done0Next;
      oDONE1    <= done1Next;
      oERR0     <= err0Next;
      oERR1     <= err1Next;
    end
  end

  // Everything advances on work-clock ticks except the one-cycle done/err pulses.
  always_comb begin
    stateNext  = state;
    ownerNext  = owner;
    preferNext = prefer;
    errNext    = errFlag;
    retryNext  = retryCnt;
    tmoNext    = tmoCnt;
    goNext     = oI2C_GO;
    dataNext   = oI2C_DATA;
    busyNext   = oBUSY;
    done0Next  = 1'b0;
    done1Next  = 1'b0;
    err0Next   = 1'b0;
    err1Next   = 1'b0;
    grant1     = iREQ1 && (!iREQ0 || prefer);

    if (oDONE0 || oDONE1) begin
      busyNext = 1'b0;
    end

    if (tick_c) begin
      case (state)
        ST_IDLE: begin
          if (iREQ0 || iREQ1) begin
            ownerNext = grant1;
            dataNext  = grant1 ? iDATA1 : iDATA0;
            retryNext = '0;
            busyNext  = 1'b1;
            stateNext = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          goNext    = 1'b1;
          tmoNext   = '0;
          stateNext = ST_WAIT;
        end
        ST_WAIT: begin
          tmoNext = tmoCnt + 8'd1;
          // END seen in the first two ticks may be left over from the previous attempt.
          if (iI2C_END && (tmoCnt >= 8'd2)) begin
            goNext = 1'b0;
            if (!iI2C_ACK) begin
              errNext   = 1'b0;
              stateNext = ST_DONE;
            end else if (retryCnt < 2'(MAX_RETRY)) begin
              retryNext = retryCnt + 2'd1;
              stateNext = ST_REISSUE;
            end else begin
              errNext   = 1'b1;
              stateNext = ST_DONE;
            end
          end else if (tmoCnt == 8'(TIMEOUT - 1)) begin
            goNext    = 1'b0;
            errNext   = 1'b1;
            stateNext = ST_DONE;
          end
        end
        ST_REISSUE: begin
          stateNext = ST_ISSUE;
        end
        ST_DONE: begin
          done0Next  = !owner;
          done1Next  = owner;
          err0Next   = !owner && errFlag;
          err1Next   = owner && errFlag;
          preferNext = ~owner;
          stateNext  = ST_IDLE;
        end
        default: begin
          stateNext = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: transaction table plus fairness, reset
// and withdrawal sequences against a small I2C controller model.
module tb_i2c_req_arbiter;
  import i2c_cfg_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iREQ0 = 1'b0, iREQ1 = 1'b0;
  logic [23:0] iDATA0 = '0, iDATA1 = '0;
  logic        oDONE0, oERR0, oDONE1, oERR1;
  logic        oCTRL_CLK, oI2C_GO, oBUSY;
  logic [23:0] oI2C_DATA;
  logic        iI2C_END = 1'b1;
  logic        iI2C_ACK = 1'b0;

  int nTests = 0;
  int nFail  = 0;

  // Controller model configuration (written by the stimulus process only)
  int attBase = 0;
  int nackCfg = 0;
  bit noEnd   = 1'b0;

  // Controller model state (written by the model only)
  bit goSeen     = 1'b0;
  int goRises    = 0;
  int endCnt     = 0;
  int lastGoLen  = 0;

  i2c_req_arbiter #(
    .CLK_FREQ (4),
    .I2C_FREQ (1),
    .MAX_RETRY(3),
    .TIMEOUT  (255)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iREQ0     (iREQ0),
    .iDATA0    (iDATA0),
    .oDONE0    (oDONE0),
    .oERR0     (oERR0),
    .iREQ1     (iREQ1),
    .iDATA1    (iDATA1),
    .oDONE1    (oDONE1),
    .oERR1     (oERR1),
    .oCTRL_CLK (oCTRL_CLK),
    .oI2C_DATA (oI2C_DATA),
    .oI2C_GO   (oI2C_GO),
    .iI2C_END  (iI2C_END),
    .iI2C_ACK  (iI2C_ACK),
    .oBUSY     (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // Controller model: END drops on GO, returns 30 cycles later with ACK/NACK.
  always @(negedge iCLK) begin
    if (oI2C_GO && !goSeen) begin
      goSeen   = 1'b1;
      goRises  = goRises + 1;
      endCnt   = 0;
      iI2C_END = 1'b0;
    end else if (oI2C_GO) begin
      endCnt = endCnt + 1;
      if (!noEnd && endCnt == 30) begin
        iI2C_END = 1'b1;
        iI2C_ACK = ((goRises - attBase) <= nackCfg);
      end
    end else if (goSeen) begin
      goSeen    = 1'b0;
      lastGoLen = endCnt + 1;
      iI2C_END  = 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        req0;
    logic        req1;
    logic [23:0] data0;
    logic [23:0] data1;
    int          nack;
    bit          noEnd;
    logic        expD0;
    logic        expD1;
    logic        expErr;
    int          expGos;
    int          expGoLen;
    logic [23:0] expData;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output logic d0, output logic d1, output logic e0, output logic e1);
    int n = 0;
    while (!(oDONE0 || oDONE1) && n < 4000) begin
      @(negedge iCLK);
      n++;
    end
    if (!(oDONE0 || oDONE1)) begin
      nTests++;
      nFail++;
      $display("FAIL done_wait: no oDONE pulse within 4000 cycles");
    end
    d0 = oDONE0;
    d1 = oDONE1;
    e0 = oERR0;
    e1 = oERR1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic d0, d1, e0, e1;
    int base;
    v       = vecs[i];
    base    = goRises;
    attBase = goRises;
    nackCfg = v.nack;
    noEnd   = v.noEnd;
    iDATA0  = v.data0;
    iDATA1  = v.data1;
    iREQ0   = v.req0;
    iREQ1   = v.req1;
    wait_done(d0, d1, e0, e1);
    iREQ0 = 1'b0;
    iREQ1 = 1'b0;
    check($sformatf("v%0d_done", i), 32'({d0, d1}), 32'({v.expD0, v.expD1}));
    check($sformatf("v%0d_err", i), 32'({e0, e1}),
          32'({v.expD0 & v.expErr, v.expD1 & v.expErr}));
    check($sformatf("v%0d_data", i), 32'(oI2C_DATA), 32'(v.expData));
    check($sformatf("v%0d_go_count", i), 32'(goRises - base), 32'(v.expGos));
    check($sformatf("v%0d_go_len", i), 32'(lastGoLen), 32'(v.expGoLen));
    @(negedge iCLK);
    check($sformatf("v%0d_pulse_width", i), 32'({oDONE0, oDONE1, oERR0, oERR1}), 32'(0));
    check($sformatf("v%0d_busy_clear", i), 32'(oBUSY), 32'(0));
    repeat (15) @(negedge iCLK);
  endtask

  initial begin
    logic d0, d1, e0, e1;
    int n0, n1, waitN;
    bit sawDone;

    vecs[0] = '{1'b1, 1'b0, {CODEC_ADDR, 16'h1A1A}, 24'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 40, 24'h341A1A};
    vecs[1] = '{1'b0, 1'b1, 24'h0, 24'h340C55, 2, 1'b0, 1'b0, 1'b1, 1'b0, 3, 40, 24'h340C55};
    vecs[2] = '{1'b0, 1'b1, 24'h0, 24'h3402FF, 9, 1'b0, 1'b0, 1'b1, 1'b1, 4, 40, 24'h3402FF};
    vecs[3] = '{1'b1, 1'b0, 24'h340A0B, 24'h0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2550, 24'h340A0B};
    vecs[4] = '{1'b1, 1'b0, 24'h340E7F, 24'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 40, 24'h340E7F};
    vecs[5] = '{1'b1, 1'b1, 24'h341111, 24'h342222, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 40, 24'h342222};
    vecs[6] = '{1'b1, 1'b1, 24'h343333, 24'h344444, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 40, 24'h343333};

    // Reset values
    repeat (3) @(negedge iCLK);
    check("reset_outputs",
          32'({oDONE0, oERR0, oDONE1, oERR1, oCTRL_CLK, oI2C_GO, oBUSY}), 32'(0));
    check("reset_data", 32'(oI2C_DATA), 32'(0));

    // Fairness: both requesting from reset alternate 0,1,0,1
    iDATA0 = 24'h340101;
    iDATA1 = 24'h340202;
    iREQ0  = 1'b1;
    iREQ1  = 1'b1;
    attBase = goRises;
    iRST_N = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 4; k++) begin
      attBase = goRises;
      wait_done(d0, d1, e0, e1);
      if (k == 3) begin
        iREQ0 = 1'b0;
        iREQ1 = 1'b0;
      end
      check($sformatf("fair%0d_owner", k), 32'({d0, d1}), (k % 2 == 0) ? 32'h2 : 32'h1);
      check($sformatf("fair%0d_data", k), 32'(oI2C_DATA),
            (k % 2 == 0) ? 32'h340101 : 32'h340202);
      n0 += int'(d0);
      n1 += int'(d1);
      @(negedge iCLK);
    end
    check("fair_count0", 32'(n0), 32'(2));
    check("fair_count1", 32'(n1), 32'(2));
    repeat (15) @(negedge iCLK);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Reset mid-transfer while req1 owns the controller and req1 would be preferred
    iDATA1  = 24'h34BEEF;
    noEnd   = 1'b1;
    nackCfg = 0;
    attBase = goRises;
    iREQ1   = 1'b1;
    waitN = 0;
    while (!oI2C_GO && waitN < 200) begin
      @(negedge iCLK);
      waitN++;
    end
    check("rst_go_seen", 32'(oI2C_GO), 32'(1));
    repeat (25) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    check("rst_async_outputs", 32'({oI2C_GO, oBUSY, oCTRL_CLK}), 32'(0));
    sawDone = 1'b0;
    repeat (20) begin
      @(negedge iCLK);
      if (oDONE0 || oDONE1) sawDone = 1'b1;
    end
    check("rst_no_done", 32'(sawDone), 32'(0));
    noEnd   = 1'b0;
    iDATA0  = 24'h345A5A;
    iREQ0   = 1'b1;
    attBase = goRises;
    iRST_N  = 1'b1;
    wait_done(d0, d1, e0, e1);
    iREQ0 = 1'b0;
    iREQ1 = 1'b0;
    check("rst_prefers_req0", 32'({d0, d1}), 32'h2);
    check("rst_req0_data", 32'(oI2C_DATA), 32'h345A5A);
    repeat (20) @(negedge iCLK);

    // Withdrawal: req1 drops and changes data two ticks after grant
    iDATA1  = 24'h34AAAA;
    attBase = goRises;
    iREQ1   = 1'b1;
    waitN = 0;
    while (!oBUSY && waitN < 200) begin
      @(negedge iCLK);
      waitN++;
    end
    check("wd_granted", 32'(oBUSY), 32'(1));
    repeat (20) @(negedge iCLK);
    iREQ1  = 1'b0;
    iDATA1 = 24'h345555;
    @(negedge iCLK);
    check("wd_data_held", 32'(oI2C_DATA), 32'h34AAAA);
    wait_done(d0, d1, e0, e1);
    check("wd_done1", 32'({d0, d1, e1}), 32'h2);
    check("wd_data_final", 32'(oI2C_DATA), 32'h34AAAA);
    repeat (20) @(negedge iCLK);
    check("wd_idle", 32'({oBUSY, oI2C_GO}), 32'(0));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
